// File: rtl/fp_pkg.sv
// Shared single-precision constants and the divider control-state encoding.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPECIAL = 2'd1,
    DIV     = 2'd2,
    NORM    = 2'd3
  } state_t;

endpackage

// File: rtl/fp_div_special.sv
// Combinational operand classifier for the divider: flags zero/inf/NaN operands
// and produces the fixed result those cases resolve to.
module fp_div_special
  import fp_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic                s;
  logic [EXP_W-1:0]    ea, eb;
  logic [FRAC_W-1:0]   fa, fb;
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  assign s  = A[31] ^ B[31];
  assign ea = A[30:23];
  assign eb = B[30:23];
  assign fa = A[22:0];
  assign fb = B[22:0];

  // Exponent 0 counts as zero whatever the fraction: denormals are flushed.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_W'(EXP_MAX)) && (fa == '0);
  assign b_inf  = (eb == EXP_W'(EXP_MAX)) && (fb == '0);
  assign a_nan  = (ea == EXP_W'(EXP_MAX)) && (fa != '0);
  assign b_nan  = (eb == EXP_W'(EXP_MAX)) && (fb != '0);

  always_comb begin
    is_special     = 1'b1;
    special_result = QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_result = QNAN;
    end else if (a_inf || b_zero) begin
      special_result = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (a_zero || b_inf) begin
      special_result = {s, {(EXP_W + FRAC_W){1'b0}}};
    end else begin
      is_special     = 1'b0;
      special_result = '0;
    end
  end

endmodule

// File: rtl/fp_divider.sv
// IEEE 754 single-precision divider: radix-2 restoring mantissa division, one
// quotient bit per cycle, truncating rounding, denormals flushed to zero.
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] O
);

  state_t        state_reg;
  logic [4:0]    cnt_reg;
  logic [24:0]   rem_reg;
  logic [23:0]   mb_reg;
  logic [24:0]   q_reg;
  logic          sign_reg;
  logic [9:0]    exp_base_reg;
  logic [31:0]   special_reg;

  logic          is_special;
  logic [31:0]   special_result;

  logic          q_bit;
  logic [24:0]   rem_sel;
  logic [24:0]   rem_next;
  logic [9:0]    exp_norm;
  logic [22:0]   frac_norm;
  logic [31:0]   norm_result;

  fp_div_special u_special (
    .A              (A),
    .B              (B),
    .is_special     (is_special),
    .special_result (special_result)
  );

  // One restoring step: subtract when the divisor fits, then shift left.
  // The kept remainder is always below mb, so bit 24 is zero before the shift.
  assign q_bit    = (rem_reg >= {1'b0, mb_reg});
  assign rem_sel  = q_bit ? (rem_reg - {1'b0, mb_reg}) : rem_reg;
  assign rem_next = {rem_sel[23:0], 1'b0};

  // exp_base_reg already holds ea - eb + 126; a leading quotient bit adds one.
  assign exp_norm  = exp_base_reg + {9'd0, q_reg[24]};
  assign frac_norm = q_reg[24] ? q_reg[23:1] : q_reg[22:0];

  always_comb begin
    norm_result = {sign_reg, exp_norm[7:0], frac_norm};
    if ($signed(exp_norm) >= $signed(10'(EXP_MAX))) begin
      norm_result = {sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if ($signed(exp_norm) <= 10'sd0) begin
      norm_result = {sign_reg, {(EXP_W + FRAC_W){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      mb_reg       <= '0;
      q_reg        <= '0;
      sign_reg     <= 1'b0;
      exp_base_reg <= '0;
      special_reg  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      O            <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            special_reg  <= special_result;
            sign_reg     <= A[31] ^ B[31];
            exp_base_reg <= {2'b00, A[30:23]} - {2'b00, B[30:23]} + 10'(BIAS - 1);
            rem_reg      <= {2'b01, A[22:0]};
            mb_reg       <= {1'b1, B[22:0]};
            q_reg        <= '0;
            cnt_reg      <= 5'd24;
            state_reg    <= is_special ? SPECIAL : DIV;
          end
        end
        SPECIAL: begin
          O         <= special_reg;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        DIV: begin
          rem_reg <= rem_next;
          q_reg   <= {q_reg[23:0], q_bit};
          if (cnt_reg == 5'd0) begin
            state_reg <= NORM;
          end else begin
            cnt_reg <= cnt_reg - 5'd1;
          end
        end
        NORM: begin
          O         <= norm_result;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
